// File: rtl/bp_fpga_host_io_arbiter.sv
// bp_fpga_host_io_arbiter
// Shares one FPGA-host IO command/response port pair among num_req_p
// requesters. Commands: round-robin with grant lock, zero-latency passthrough.
// Responses: returned in order, steered back via a requester-ID FIFO.
//
// Handshake semantics: a transfer happens on a cycle where valid and
// ready are both high. A valid, once raised, is held with stable data
// until it is accepted. resp_yumi_i / io_resp_yumi_o are "yumi" style:
// they may only be raised while the matching valid is high and mean
// "consumed this cycle".
module bp_fpga_host_io_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4,
  localparam int req_id_width_lp  = (num_req_p <= 1) ? 1 : $clog2(num_req_p),
  localparam int cnt_width_lp     = $clog2(max_outstanding_p + 1),
  localparam int ptr_width_lp     = $clog2(max_outstanding_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]             cmd_v_i,
  output logic [num_req_p-1:0]             cmd_ready_and_o,
  output logic [msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_yumi_i,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_ready_and_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_yumi_o,
  output logic [cnt_width_lp-1:0]          outstanding_o,
  output logic                             error_o
);

  // Arbitration state
  logic [req_id_width_lp-1:0] last_r;
  logic                       lock_r;
  logic [req_id_width_lp-1:0] locked_id_r;

  // Requester-ID FIFO state
  logic [req_id_width_lp-1:0] id_mem_r [max_outstanding_p];
  logic [ptr_width_lp-1:0]    wptr_r;
  logic [ptr_width_lp-1:0]    rptr_r;
  logic [cnt_width_lp-1:0]    count_r;
  logic                       error_r;

  // Combinational signals
  logic [req_id_width_lp-1:0] cand;
  logic [req_id_width_lp-1:0] rr_pick;
  logic                       rr_found;
  logic [req_id_width_lp-1:0] winner;
  logic                       any_v;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic                       orphan;
  logic [req_id_width_lp-1:0] head_id;

  assign full    = (count_r == cnt_width_lp'(max_outstanding_p));
  assign empty   = (count_r == '0);
  assign head_id = id_mem_r[rptr_r];

  // Round-robin search starting just after the last granted requester
  always_comb begin
    cand     = '0;
    rr_pick  = last_r;
    rr_found = 1'b0;
    for (int k = 1; k <= num_req_p; k++) begin
      cand = req_id_width_lp'((int'(last_r) + k) % num_req_p);
      if (!rr_found && cmd_v_i[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  // A locked grant overrides priority until the host accepts it
  always_comb begin
    winner = lock_r ? locked_id_r : rr_pick;
    any_v  = lock_r ? cmd_v_i[locked_id_r] : rr_found;
  end

  // Command passthrough and per-requester ready
  always_comb begin
    io_cmd_o        = cmd_i[winner*msg_width_p +: msg_width_p];
    io_cmd_v_o      = any_v & ~full;
    push            = io_cmd_v_o & io_cmd_ready_and_i;
    cmd_ready_and_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cmd_ready_and_o[i] = push && (winner == req_id_width_lp'(i));
    end
  end

  // Response steering to the head-of-FIFO owner; orphans are dropped
  always_comb begin
    resp_o   = io_resp_i;
    resp_v_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      resp_v_o[i] = io_resp_v_i && !empty && (head_id == req_id_width_lp'(i));
    end
    pop            = io_resp_v_i & ~empty & resp_yumi_i[head_id];
    orphan         = io_resp_v_i & empty;
    io_resp_yumi_o = pop | orphan;
  end

  // Round-robin pointer and grant lock
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_r      <= req_id_width_lp'(num_req_p - 1);
      lock_r      <= 1'b0;
      locked_id_r <= '0;
    end else begin
      if (push) begin
        last_r <= winner;
        lock_r <= 1'b0;
      end else if (io_cmd_v_o) begin
        lock_r      <= 1'b1;
        locked_id_r <= winner;
      end
    end
  end

  // ID FIFO pointers, occupancy and sticky orphan error
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      error_r <= 1'b0;
    end else begin
      if (push) wptr_r <= wptr_r + 1'b1;
      if (pop)  rptr_r <= rptr_r + 1'b1;
      count_r <= count_r + cnt_width_lp'(push) - cnt_width_lp'(pop);
      if (orphan) error_r <= 1'b1;
    end
  end

  // ID storage; contents are meaningless outside the valid window
  always_ff @(posedge clk_i) begin
    if (push) id_mem_r[wptr_r] <= winner;
  end

  assign outstanding_o = count_r;
  assign error_o       = error_r;

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i) !(pop && empty));
  a_resp_onehot0: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(resp_v_o));
  a_lock_hold:    assert property (@(posedge clk_i) disable iff (reset_i) lock_r |-> cmd_v_i[locked_id_r]);
`endif

endmodule

// File: tb/tb_bp_fpga_host_io_arbiter.sv
// Directed bench for bp_fpga_host_io_arbiter (2 requesters, depth 4).
module tb_bp_fpga_host_io_arbiter;

  localparam int n_req = 2;
  localparam int mw    = 128;
  localparam int mo    = 4;
  localparam int cw    = 3;

  logic              clk;
  logic              reset_i;
  logic [n_req*mw-1:0] cmd_i;
  logic [n_req-1:0]  cmd_v_i;
  logic [n_req-1:0]  cmd_ready_and_o;
  logic [mw-1:0]     resp_o;
  logic [n_req-1:0]  resp_v_o;
  logic [n_req-1:0]  resp_yumi_i;
  logic [mw-1:0]     io_cmd_o;
  logic              io_cmd_v_o;
  logic              io_cmd_ready_and_i;
  logic [mw-1:0]     io_resp_i;
  logic              io_resp_v_i;
  logic              io_resp_yumi_o;
  logic [cw-1:0]     outstanding_o;
  logic              error_o;

  int checks = 0;
  int errors = 0;

  localparam logic [mw-1:0] msg_r1 = 128'h41_0010_1000;
  localparam logic [mw-1:0] msg_a0 = 128'hA0A0_0000_0000_0000_0000_0000_0000_00A0;
  localparam logic [mw-1:0] msg_b1 = 128'hB1B1_1111_2222_3333_4444_5555_6666_77B1;
  localparam logic [mw-1:0] rsp_1  = 128'h0000_0000_0000_0000_0000_0000_5253_5031;

  bp_fpga_host_io_arbiter #(
    .num_req_p(n_req), .msg_width_p(mw), .max_outstanding_p(mo)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [mw-1:0] obs, input logic [mw-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    cmd_i = '0; cmd_v_i = '0; resp_yumi_i = '0;
    io_cmd_ready_and_i = 1'b0; io_resp_i = '0; io_resp_v_i = 1'b0;
    step(); step();
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_io_cmd_v", io_cmd_v_o, 0);
    chk("rst_cmd_ready", cmd_ready_and_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_io_resp_yumi", io_resp_yumi_o, 0);
    reset_i = 1'b0;
    step();

    // Single requester: req1 command, response, yumi
    cmd_i = {msg_r1, msg_a0};
    cmd_v_i = 2'b10; io_cmd_ready_and_i = 1'b1;
    settle();
    chk("single_io_cmd", io_cmd_o, msg_r1);
    chk("single_io_cmd_v", io_cmd_v_o, 1);
    chk("single_ready", cmd_ready_and_o, 2'b10);
    step();
    cmd_v_i = 2'b00;
    chk("single_outstanding1", outstanding_o, 1);
    io_resp_i = rsp_1; io_resp_v_i = 1'b1; resp_yumi_i = 2'b00;
    settle();
    chk("single_resp_v", resp_v_o, 2'b10);
    chk("single_resp_data", resp_o, rsp_1);
    chk("single_no_yumi", io_resp_yumi_o, 0);
    resp_yumi_i = 2'b01;
    settle();
    chk("single_foreign_yumi", io_resp_yumi_o, 0);
    resp_yumi_i = 2'b10;
    settle();
    chk("single_yumi", io_resp_yumi_o, 1);
    step();
    io_resp_v_i = 1'b0; resp_yumi_i = 2'b00;
    chk("single_outstanding0", outstanding_o, 0);

    // Fairness: both valid, host ready; grants alternate starting at 0
    cmd_i = {msg_b1, msg_a0};
    cmd_v_i = 2'b11;
    settle();
    chk("fair_g0", cmd_ready_and_o, 2'b01);
    chk("fair_g0_data", io_cmd_o, msg_a0);
    step();
    chk("fair_g1", cmd_ready_and_o, 2'b10);
    chk("fair_g1_data", io_cmd_o, msg_b1);
    step();
    chk("fair_g2", cmd_ready_and_o, 2'b01);
    step();
    chk("fair_g3", cmd_ready_and_o, 2'b10);
    step();

    // Full: four outstanding, nothing accepted
    chk("full_outstanding", outstanding_o, 4);
    chk("full_io_cmd_v", io_cmd_v_o, 0);
    chk("full_ready", cmd_ready_and_o, 2'b00);
    // Pop while full: still a bubble this cycle
    io_resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    settle();
    chk("full_pop_resp_v", resp_v_o, 2'b01);
    chk("full_pop_bubble", io_cmd_v_o, 0);
    step();
    io_resp_v_i = 1'b0; resp_yumi_i = 2'b00;
    settle();
    chk("full_after_pop_cnt", outstanding_o, 3);
    chk("full_after_pop_v", io_cmd_v_o, 1);
    chk("full_after_pop_grant", cmd_ready_and_o, 2'b01);
    step();
    cmd_v_i = 2'b00;
    chk("refill_cnt", outstanding_o, 4);

    // Ordering: FIFO holds 1,0,1,0
    io_resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    settle();
    chk("order_r0", resp_v_o, 2'b10);
    step();
    chk("order_r1", resp_v_o, 2'b01);
    step();
    chk("order_r2", resp_v_o, 2'b10);
    step();
    chk("order_r3", resp_v_o, 2'b01);
    step();
    io_resp_v_i = 1'b0; resp_yumi_i = 2'b00;
    chk("order_drained", outstanding_o, 0);
    chk("order_no_error", error_o, 0);

    // Backpressure lock: last grant was 0, so 1 would win without the lock
    io_cmd_ready_and_i = 1'b0;
    cmd_v_i = 2'b01;
    settle();
    chk("lock_c0_data", io_cmd_o, msg_a0);
    chk("lock_c0_ready", cmd_ready_and_o, 2'b00);
    step();
    cmd_v_i = 2'b11;
    for (int c = 1; c < 5; c++) begin
      settle();
      chk("lock_hold_data", io_cmd_o, msg_a0);
      chk("lock_hold_v", io_cmd_v_o, 1);
      step();
    end
    io_cmd_ready_and_i = 1'b1;
    settle();
    chk("lock_accept", cmd_ready_and_o, 2'b01);
    step();
    cmd_v_i = 2'b10;
    settle();
    chk("lock_next_grant", cmd_ready_and_o, 2'b10);
    chk("lock_next_data", io_cmd_o, msg_b1);
    step();
    cmd_v_i = 2'b00; io_cmd_ready_and_i = 1'b0;
    chk("lock_outstanding", outstanding_o, 2);
    io_resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    settle();
    chk("lock_resp0", resp_v_o, 2'b01);
    step();
    chk("lock_resp1", resp_v_o, 2'b10);
    step();
    io_resp_v_i = 1'b0; resp_yumi_i = 2'b00;
    chk("lock_drained", outstanding_o, 0);

    // Orphan response: dropped, sticky error
    io_resp_v_i = 1'b1;
    settle();
    chk("orphan_yumi", io_resp_yumi_o, 1);
    chk("orphan_resp_v", resp_v_o, 2'b00);
    step();
    io_resp_v_i = 1'b0;
    chk("orphan_error", error_o, 1);
    step();
    chk("orphan_sticky", error_o, 1);

    // Leave one command pending (grant 0), then reset
    cmd_v_i = 2'b01; io_cmd_ready_and_i = 1'b1;
    step();
    cmd_v_i = 2'b00;
    chk("pre_reset_cnt", outstanding_o, 1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("post_reset_error", error_o, 0);
    chk("post_reset_cnt", outstanding_o, 0);
    cmd_v_i = 2'b11;
    settle();
    chk("post_reset_prio", cmd_ready_and_o, 2'b01);
    step();
    cmd_v_i = 2'b00; io_cmd_ready_and_i = 1'b0;
    chk("post_reset_push", outstanding_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fpga_host_io_arbiter.md
Name: bp_fpga_host_io_arbiter

Overview:
- Shares the single FPGA-host IO command/response port pair among num_req_p requesters, for example core putchar traffic and a debug/loopback sender.
- Command path: round-robin arbitration with grant lock, zero-latency passthrough of the winning command to the host.
- Response path: responses return in order; a requester-ID FIFO steers each response back to the requester that issued the matching command.
- Sits between requesters and the host's io_cmd_i / io_resp_o side.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- msg_width_p, 128, width of one bedrock IO mem message (header + data), treated as opaque.
- max_outstanding_p, 4, maximum commands accepted by the host whose responses have not yet been consumed (power of 2, ≥2).
- req_id_width_lp, `BSG_SAFE_CLOG2(num_req_p)`, derived.
- cnt_width_lp, `BSG_WIDTH(max_outstanding_p)`, derived.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- cmd_i  in  num_req_p*msg_width_p  requester commands; slice i belongs to requester i.
- cmd_v_i  in  num_req_p  command valid per requester.
- cmd_ready_and_o  out  num_req_p  command accepted this cycle (ready&valid handshake).
- resp_o  out  msg_width_p  response, broadcast to all requesters.
- resp_v_o  out  num_req_p  response valid, one-hot to the owning requester.
- resp_yumi_i  in  num_req_p  response consumed.
- io_cmd_o  out  msg_width_p  command to host.
- io_cmd_v_o  out  1  command valid to host.
- io_cmd_ready_and_i  in  1  host ready.
- io_resp_i  in  msg_width_p  response from host.
- io_resp_v_i  in  1  host response valid.
- io_resp_yumi_o  out  1  response dequeue to host.
- outstanding_o  out  cnt_width_lp  current ID FIFO occupancy.
- error_o  out  1  sticky: host response arrived with no outstanding command.

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointer last_r = num_req_p-1, so requester 0 has top priority first.
  - Lock clear, ID FIFO empty, error_o = 0.
  - Reset mid-transaction discards all pending IDs; responses still in flight then hit the error rule below.
- Arbitration (combinational):
  - Search order is last_r+1, last_r+2, … modulo num_req_p; the first requester with cmd_v_i set wins.
  - io_cmd_o = cmd_i slice of the winner.
  - io_cmd_v_o = any valid & ~full.
  - full = (count == max_outstanding_p).
  - While full: io_cmd_v_o = 0 and every cmd_ready_and_o = 0.
- Grant lock:
  - If io_cmd_v_o=1 and io_cmd_ready_and_i=0, register lock_r=1 and locked_id_r=winner.
  - While locked, the winner is forced to locked_id_r regardless of priority; the requester must hold v and data per ready/valid.
  - Lock clears on acceptance.
- Command accept:
  - Accept when io_cmd_v_o & io_cmd_ready_and_i.
  - In the same cycle: cmd_ready_and_o[winner]=1 only; push winner ID into the FIFO; last_r <= winner.
  - Latency is 0 cycles requester-to-host; at most 1 command per cycle.
- Response steering:
  - When io_resp_v_i & ~empty: resp_v_o[head_id]=1, others 0, and resp_o = io_resp_i.
  - io_resp_yumi_o = resp_yumi_i[head_id] & resp_v_o[head_id]; this pops the FIFO.
  - resp_yumi_i on non-owning bits is ignored.
- Orphan response:
  - If io_resp_v_i=1 while empty: io_resp_yumi_o=1 (drop), resp_v_o=0, error_o set.
  - error_o clears only on reset.
- Simultaneous push and pop:
  - Allowed; count is unchanged.
  - Full is evaluated on registered count, so a pop in the same cycle does not admit a push (one bubble when full, by design).
- Counter arithmetic:
  - count_n = count + push - pop.
  - Wrap-safe pointers of log2(max_outstanding_p) bits.
  - outstanding_o = count, registered.
- Assertions (sim only): no push when full; no pop when empty; resp_v_o is onehot0; cmd_v_i of the locked requester must not drop while locked.

Test Plan:
- Single requester: req1 sends cmd with data 0x41 addr 0x0010_1000, host ready → io_cmd_o = req1 slice in the same cycle, cmd_ready_and_o = 2'b10, outstanding_o = 1; host response → resp_v_o = 2'b10; yumi → outstanding_o = 0.
- Fairness: num_req_p=2, both valid continuously, host always ready → grants alternate 0,1,0,1…; starting from reset the first grant is requester 0.
- Backpressure lock: req0 valid, io_cmd_ready_and_i = 0 for 5 cycles while req1 also raises valid → io_cmd_o stays req0 for all 5 cycles; on ready, req0 accepted, next grant req1.
- Full: max_outstanding_p=4, 4 commands accepted with no responses → io_cmd_v_o = 0, cmd_ready_and_o = 0, outstanding_o = 4; one response consumed → a command is accepted on the following cycle.
- Ordering: accepted IDs 1,0,1 → three host responses are steered to resp_v_o = 10, 01, 10 in that order.
- Orphan response plus reset: io_resp_v_i with FIFO empty → io_resp_yumi_o = 1, error_o = 1 and it stays set; assert reset_i for 1 cycle → error_o = 0, outstanding_o = 0, priority back at requester 0.
